// File: rtl/multiplexer_rr_n.sv
// rtl/multiplexer_rr_n.sv - N-input registered mux/arbiter, static-select or round-robin
module multiplexer_rr_n #(
  parameter int NR_OF_INPUTS   = 4,
  parameter int NR_OF_BITS     = 32,
  parameter int NR_OF_SEL_BITS = 2
) (
  input  logic                                 Clock,
  input  logic                                 nReset,
  input  logic                                 Enable,
  input  logic                                 Mode,
  input  logic [NR_OF_SEL_BITS-1:0]            Sel,
  input  logic [NR_OF_INPUTS*NR_OF_BITS-1:0]   MuxIn,
  input  logic [NR_OF_INPUTS-1:0]              InValid,
  output logic [NR_OF_INPUTS-1:0]              InReady,
  output logic [NR_OF_BITS-1:0]                MuxOut,
  output logic                                 OutValid,
  input  logic                                 OutReady,
  output logic [NR_OF_SEL_BITS-1:0]            GrantIdx
);

  localparam int N  = NR_OF_INPUTS;
  localparam int W  = NR_OF_BITS;
  localparam int SW = NR_OF_SEL_BITS;

  logic [W-1:0]  mux_out_q;
  logic          out_valid_q;
  logic [SW-1:0] grant_idx_q;
  logic [SW-1:0] ptr_q;

  logic          slot_free;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  req_rot;
  logic [W-1:0]  grant_word;
  logic          transfer;

  // (base + offs) mod N, valid for base < N and offs <= N
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N) sum = sum - N;
    return SW'(sum);
  endfunction

  assign slot_free = ~out_valid_q | OutReady;

  // Requests rotated so bit j is channel (ptr + j) mod N
  assign req_rot = N'({InValid, InValid} >> ptr_q);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (Enable && slot_free) begin
      if (!Mode) begin
        for (int i = 0; i < N; i++) begin
          if (SW'(i) == Sel && InValid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SW'(i);
          end
        end
      end else begin
        for (int j = 0; j < N; j++) begin
          if (!grant_valid && req_rot[j]) begin
            grant_valid = 1'b1;
            grant_idx   = wrap_add(ptr_q, j);
          end
        end
      end
    end
  end

  always_comb begin
    InReady    = '0;
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant_idx) begin
        InReady[i] = grant_valid & nReset;
        grant_word = MuxIn[i*W +: W];
      end
    end
  end

  assign transfer = |(InReady & InValid);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mux_out_q   <= '0;
      out_valid_q <= 1'b0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      if (transfer) begin
        mux_out_q   <= grant_word;
        grant_idx_q <= grant_idx;
        out_valid_q <= 1'b1;
        if (Mode) ptr_q <= wrap_add(grant_idx, 1);
      end else if (out_valid_q && OutReady) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign MuxOut   = mux_out_q;
  assign OutValid = out_valid_q;
  assign GrantIdx = grant_idx_q;

endmodule

// File: tb/tb_multiplexer_rr_n.sv
// tb/tb_multiplexer_rr_n.sv - directed table-driven bench for multiplexer_rr_n
module tb_multiplexer_rr_n;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 3;

  logic            clock;
  logic            n_reset;
  logic            enable;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  mux_in;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    mux_out;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   grant_idx;

  int checks = 0;
  int errors = 0;

  multiplexer_rr_n #(
    .NR_OF_INPUTS  (N),
    .NR_OF_BITS    (W),
    .NR_OF_SEL_BITS(SW)
  ) dut (
    .Clock   (clock),
    .nReset  (n_reset),
    .Enable  (enable),
    .Mode    (mode),
    .Sel     (sel),
    .MuxIn   (mux_in),
    .InValid (in_valid),
    .InReady (in_ready),
    .MuxOut  (mux_out),
    .OutValid(out_valid),
    .OutReady(out_ready),
    .GrantIdx(grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          en;
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  iv;
    logic          rdy;
    logic [N-1:0]  exp_in_ready;
    logic          exp_ov;
    logic [SW-1:0] exp_gi;
    logic [W-1:0]  exp_mo;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic md, input logic [SW-1:0] s,
                       input logic [N-1:0] iv, input logic rdy);
    enable    = en;
    mode      = md;
    sel       = s;
    in_valid  = iv;
    out_ready = rdy;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mux_in[i*W +: W] = 32'hA5A5_0000 | 32'(i);

    // Ptr walk: 0 ->static grants leave it, RR 0,1,2,3,0 then 3,0,3,0 on 1001
    tbl[0]  = '{1'b1, 1'b0, 3'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 3'd2, 32'hA5A5_0002};
    tbl[1]  = '{1'b1, 1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd2, 32'hA5A5_0002};
    tbl[2]  = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[3]  = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 3'd1, 32'hA5A5_0001};
    tbl[4]  = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 3'd2, 32'hA5A5_0002};
    tbl[5]  = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3'd3, 32'hA5A5_0003};
    tbl[6]  = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[7]  = '{1'b1, 1'b1, 3'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 3'd3, 32'hA5A5_0003};
    tbl[8]  = '{1'b1, 1'b1, 3'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[9]  = '{1'b1, 1'b1, 3'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 3'd3, 32'hA5A5_0003};
    tbl[10] = '{1'b1, 1'b1, 3'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[11] = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[12] = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[13] = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd0, 32'hA5A5_0000};
    tbl[14] = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 3'd1, 32'hA5A5_0001};
    tbl[15] = '{1'b0, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd1, 32'hA5A5_0001};
    tbl[16] = '{1'b0, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd1, 32'hA5A5_0001};
    tbl[17] = '{1'b1, 1'b0, 3'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 3'd3, 32'hA5A5_0003};
    tbl[18] = '{1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 3'd2, 32'hA5A5_0002};
    tbl[19] = '{1'b1, 1'b0, 3'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 3'd2, 32'hA5A5_0002};

    // Reset held with requests present: nothing may be accepted
    n_reset = 1'b0;
    drive(1'b1, 1'b1, 3'd0, 4'b1111, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_mux_out", mux_out, 32'h0);
    check("reset_grant_idx", 32'(grant_idx), 32'h0);

    @(negedge clock);
    n_reset = 1'b1;
    drive(1'b1, 1'b1, 3'd0, 4'b0000, 1'b1);
    @(posedge clock);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h0);
    check("idle_out_valid", 32'(out_valid), 32'h0);

    for (int v = 0; v < NV; v++) begin
      drive(tbl[v].en, tbl[v].mode, tbl[v].sel, tbl[v].iv, tbl[v].rdy);
      #1;
      check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(tbl[v].exp_in_ready));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(tbl[v].exp_ov));
      check($sformatf("v%0d_grant_idx", v), 32'(grant_idx), 32'(tbl[v].exp_gi));
      check($sformatf("v%0d_mux_out", v), mux_out, tbl[v].exp_mo);
    end

    // Load ch2 in RR mode (Ptr -> 3), hold it, then reset between edges
    drive(1'b1, 1'b1, 3'd0, 4'b0100, 1'b0);
    @(posedge clock);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'h1);
    check("pre_reset_grant_idx", 32'(grant_idx), 32'h2);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_mux_out", mux_out, 32'h0);
    check("async_grant_idx", 32'(grant_idx), 32'h0);
    check("async_in_ready", 32'(in_ready), 32'h0);

    @(negedge clock);
    n_reset = 1'b1;
    drive(1'b1, 1'b1, 3'd0, 4'b1010, 1'b1);
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'h2);
    @(posedge clock);
    #1;
    check("post_reset_grant_idx", 32'(grant_idx), 32'h1);
    check("post_reset_mux_out", mux_out, 32'hA5A5_0001);
    check("post_reset_out_valid", 32'(out_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
